// File: rtl/range_monitor_real.sv
// Multi-channel range monitor for signed fixed-point samples: per-channel inclusive bound check,
// sticky flags, saturating counters, min/max peaks and a frozen first-violation record.
module range_monitor_real #(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 16,
    parameter int EXPONENT  = -8,
    parameter int CNT_WIDTH = 8,
    parameter bit HALT      = 1'b0,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [N_CH*WIDTH-1:0]     in_data,
    input  logic [N_CH*WIDTH-1:0]     lo_bound,
    input  logic [N_CH*WIDTH-1:0]     hi_bound,
    input  logic                      clear,
    output logic [N_CH-1:0]           viol_now,
    output logic [N_CH-1:0]           viol_sticky,
    output logic                      viol_any,
    output logic [N_CH*CNT_WIDTH-1:0] viol_count,
    output logic                      first_valid,
    output logic [CH_W-1:0]           first_ch,
    output logic [WIDTH-1:0]          first_data,
    output logic                      peak_valid,
    output logic [N_CH*WIDTH-1:0]     peak_min,
    output logic [N_CH*WIDTH-1:0]     peak_max
);

    localparam logic [WIDTH-1:0]     MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic signed [WIDTH-1:0] x_s  [N_CH];
    logic signed [WIDTH-1:0] lo_s [N_CH];
    logic signed [WIDTH-1:0] hi_s [N_CH];
    logic [N_CH-1:0]         viol_s;
    logic [CH_W-1:0]         low_ch_s;
    logic [WIDTH-1:0]        low_data_s;
    logic                    capture_s;

    logic [N_CH-1:0]           viol_now_q,    viol_now_d;
    logic [N_CH-1:0]           sticky_q,      sticky_d;
    logic [N_CH*CNT_WIDTH-1:0] cnt_q,         cnt_d;
    logic                      first_valid_q, first_valid_d;
    logic [CH_W-1:0]           first_ch_q,    first_ch_d;
    logic [WIDTH-1:0]          first_data_q,  first_data_d;
    logic                      peak_valid_q,  peak_valid_d;
    logic [N_CH*WIDTH-1:0]     min_q,         min_d;
    logic [N_CH*WIDTH-1:0]     max_q,         max_d;

    // An inverted window (lo > hi) makes both halves of the test fail for some side, so every sample violates.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign x_s[c]    = $signed(in_data[c*WIDTH +: WIDTH]);
        assign lo_s[c]   = $signed(lo_bound[c*WIDTH +: WIDTH]);
        assign hi_s[c]   = $signed(hi_bound[c*WIDTH +: WIDTH]);
        assign viol_s[c] = (x_s[c] < lo_s[c]) || (x_s[c] > hi_s[c]);
    end

    // Lowest violating channel; scanning downward lets the lowest index win.
    always_comb begin
        low_ch_s   = {CH_W{1'b0}};
        low_data_s = {WIDTH{1'b0}};
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (viol_s[c]) begin
                low_ch_s   = CH_W'(c);
                low_data_s = in_data[c*WIDTH +: WIDTH];
            end else begin
                low_ch_s   = low_ch_s;
                low_data_s = low_data_s;
            end
        end
    end

    assign capture_s = in_valid && !clear && !first_valid_q && (|viol_s);

    // Next-state logic: clear dominates, a valid sample updates, otherwise only viol_now drops.
    always_comb begin
        viol_now_d    = {N_CH{1'b0}};
        sticky_d      = sticky_q;
        cnt_d         = cnt_q;
        first_valid_d = first_valid_q;
        first_ch_d    = first_ch_q;
        first_data_d  = first_data_q;
        peak_valid_d  = peak_valid_q;
        min_d         = min_q;
        max_d         = max_q;
        if (clear) begin
            sticky_d      = {N_CH{1'b0}};
            cnt_d         = {(N_CH*CNT_WIDTH){1'b0}};
            first_valid_d = 1'b0;
            first_ch_d    = {CH_W{1'b0}};
            first_data_d  = {WIDTH{1'b0}};
            peak_valid_d  = 1'b0;
            min_d         = {N_CH{MOST_POS}};
            max_d         = {N_CH{MOST_NEG}};
        end else if (in_valid) begin
            viol_now_d   = viol_s;
            sticky_d     = sticky_q | viol_s;
            peak_valid_d = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (viol_s[c] && (cnt_q[c*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)) begin
                    cnt_d[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c*CNT_WIDTH +: CNT_WIDTH] + CNT_ONE;
                end else begin
                    cnt_d[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c*CNT_WIDTH +: CNT_WIDTH];
                end
                if (x_s[c] < $signed(min_q[c*WIDTH +: WIDTH])) begin
                    min_d[c*WIDTH +: WIDTH] = x_s[c];
                end else begin
                    min_d[c*WIDTH +: WIDTH] = min_q[c*WIDTH +: WIDTH];
                end
                if (x_s[c] > $signed(max_q[c*WIDTH +: WIDTH])) begin
                    max_d[c*WIDTH +: WIDTH] = x_s[c];
                end else begin
                    max_d[c*WIDTH +: WIDTH] = max_q[c*WIDTH +: WIDTH];
                end
            end
            if (capture_s) begin
                first_valid_d = 1'b1;
                first_ch_d    = low_ch_s;
                first_data_d  = low_data_s;
            end else begin
                first_valid_d = first_valid_q;
            end
        end else begin
            viol_now_d = {N_CH{1'b0}};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_now_q    <= {N_CH{1'b0}};
            sticky_q      <= {N_CH{1'b0}};
            cnt_q         <= {(N_CH*CNT_WIDTH){1'b0}};
            first_valid_q <= 1'b0;
            first_ch_q    <= {CH_W{1'b0}};
            first_data_q  <= {WIDTH{1'b0}};
            peak_valid_q  <= 1'b0;
            min_q         <= {N_CH{MOST_POS}};
            max_q         <= {N_CH{MOST_NEG}};
        end else begin
            viol_now_q    <= viol_now_d;
            sticky_q      <= sticky_d;
            cnt_q         <= cnt_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            first_data_q  <= first_data_d;
            peak_valid_q  <= peak_valid_d;
            min_q         <= min_d;
            max_q         <= max_d;
        end
    end

    assign viol_now    = viol_now_q;
    assign viol_sticky = sticky_q;
    assign viol_any    = |sticky_q;
    assign viol_count  = cnt_q;
    assign first_valid = first_valid_q;
    assign first_ch    = first_ch_q;
    assign first_data  = first_data_q;
    assign peak_valid  = peak_valid_q;
    assign peak_min    = min_q;
    assign peak_max    = max_q;

`ifndef SYNTHESIS
    function automatic real to_real(input logic signed [WIDTH-1:0] v);
        return $itor(v) * (2.0 ** EXPONENT);
    endfunction

    // Simulation-only halt on the first captured violation.
    always @(posedge clk) begin
        if (HALT && rst_n && capture_s) begin
            $display("range_monitor_real: violation on ch%0d value %f bounds [%f, %f]",
                     low_ch_s, to_real(x_s[low_ch_s]), to_real(lo_s[low_ch_s]), to_real(hi_s[low_ch_s]));
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_range_monitor_real.sv
// Directed-vector bench for range_monitor_real with hand-computed expectations (N_CH=4, WIDTH=16, CNT_WIDTH=8).
module tb_range_monitor_real;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [63:0] lo_bound;
    logic [63:0] hi_bound;
    logic        clear;
    logic [3:0]  viol_now;
    logic [3:0]  viol_sticky;
    logic        viol_any;
    logic [31:0] viol_count;
    logic        first_valid;
    logic [1:0]  first_ch;
    logic [15:0] first_data;
    logic        peak_valid;
    logic [63:0] peak_min;
    logic [63:0] peak_max;

    int n_checks = 0;
    int n_errors = 0;

    range_monitor_real dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .lo_bound(lo_bound), .hi_bound(hi_bound), .clear(clear),
        .viol_now(viol_now), .viol_sticky(viol_sticky), .viol_any(viol_any),
        .viol_count(viol_count), .first_valid(first_valid), .first_ch(first_ch),
        .first_data(first_data), .peak_valid(peak_valid),
        .peak_min(peak_min), .peak_max(peak_max)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                          input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 64'h0;
        lo_bound = 64'h0;
        hi_bound = 64'h0;
        clear    = 1'b0;
        #12;
        check_eq("rst_peak_min", peak_min, {4{16'h7FFF}});
        check_eq("rst_peak_max", peak_max, {4{16'h8000}});
        check_eq("rst_count", {32'h0, viol_count}, 64'h0);
        check_eq("rst_flags", {58'h0, viol_now, viol_any, first_valid}, 64'h0);
        check_eq("rst_peak_valid", {63'h0, peak_valid}, 64'h0);
        rst_n = 1'b1;

        // In-range including both boundaries
        lo_bound = {4{16'hFF9C}};
        hi_bound = {4{16'h0064}};
        in_valid = 1'b1;
        in_data  = pack4(16'hFF9C, 16'h0064, 16'h0000, 16'h0000);
        tick();
        check_eq("inrange_now", {60'h0, viol_now}, 64'h0);
        check_eq("inrange_count", {32'h0, viol_count}, 64'h0);
        check_eq("inrange_min0", {48'h0, peak_min[15:0]}, 64'hFF9C);
        check_eq("inrange_max1", {48'h0, peak_max[31:16]}, 64'h0064);
        check_eq("inrange_max0", {48'h0, peak_max[15:0]}, 64'hFF9C);
        check_eq("inrange_pvalid", {63'h0, peak_valid}, 64'h1);
        check_eq("inrange_any", {63'h0, viol_any}, 64'h0);

        // Idle cycle with out-of-range garbage must change nothing
        in_valid = 1'b0;
        in_data  = pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        tick();
        check_eq("idle_max0", {48'h0, peak_max[15:0]}, 64'hFF9C);
        check_eq("idle_sticky", {60'h0, viol_sticky}, 64'h0);

        // Simultaneous violation on ch1 (101) and ch3 (-101)
        in_valid = 1'b1;
        in_data  = pack4(16'h0000, 16'h0065, 16'h0000, 16'hFF9B);
        tick();
        check_eq("simul_now", {60'h0, viol_now}, 64'hA);
        check_eq("simul_sticky", {60'h0, viol_sticky}, 64'hA);
        check_eq("simul_first", {45'h0, first_valid, first_ch, first_data}, {45'h0, 1'b1, 2'd1, 16'h0065});
        check_eq("simul_count", {32'h0, viol_count}, {32'h0, 32'h01000100});
        check_eq("simul_min3", {48'h0, peak_min[63:48]}, 64'hFF9B);
        check_eq("simul_any", {63'h0, viol_any}, 64'h1);

        in_data = pack4(16'h01F4, 16'h0000, 16'h0000, 16'h0000);
        tick();
        check_eq("later_now", {60'h0, viol_now}, 64'h1);
        check_eq("later_sticky", {60'h0, viol_sticky}, 64'hB);
        check_eq("later_first", {46'h0, first_ch, first_data}, {46'h0, 2'd1, 16'h0065});
        check_eq("later_count", {32'h0, viol_count}, {32'h0, 32'h01000101});

        // Clear together with a violating sample discards the sample
        clear   = 1'b1;
        in_data = pack4(16'h0000, 16'h0000, 16'h03E8, 16'h0000);
        tick();
        clear = 1'b0;
        check_eq("clr_count", {32'h0, viol_count}, 64'h0);
        check_eq("clr_flags", {57'h0, viol_now, viol_any, first_valid, peak_valid}, 64'h0);
        check_eq("clr_sticky", {60'h0, viol_sticky}, 64'h0);
        check_eq("clr_min", peak_min, {4{16'h7FFF}});
        check_eq("clr_max", peak_max, {4{16'h8000}});

        // Saturation: 300 consecutive violations on ch2 (1000)
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0) begin
                check_eq("recap_first", {45'h0, first_valid, first_ch, first_data}, {45'h0, 1'b1, 2'd2, 16'h03E8});
            end else if (i == 253) begin
                check_eq("sat_254", {32'h0, viol_count}, {32'h0, 32'h00FE0000});
            end else if (i == 254) begin
                check_eq("sat_255", {32'h0, viol_count}, {32'h0, 32'h00FF0000});
            end
        end
        check_eq("sat_hold", {32'h0, viol_count}, {32'h0, 32'h00FF0000});
        check_eq("sat_sticky", {60'h0, viol_sticky}, 64'h4);
        check_eq("sat_max2", {48'h0, peak_max[47:32]}, 64'h03E8);

        // Inverted bounds: every sample violates
        lo_bound = {4{16'h000A}};
        hi_bound = {4{16'hFFF6}};
        in_data  = 64'h0;
        tick();
        check_eq("inv_now", {60'h0, viol_now}, 64'hF);
        check_eq("inv_count", {32'h0, viol_count}, {32'h0, 32'h01FF0101});
        in_valid = 1'b0;
        tick();
        check_eq("gap_now", {60'h0, viol_now}, 64'h0);
        check_eq("gap_count", {32'h0, viol_count}, {32'h0, 32'h01FF0101});
        check_eq("gap_sticky", {60'h0, viol_sticky}, 64'hF);

        // Asynchronous reset mid-cycle takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", {32'h0, viol_count}, 64'h0);
        check_eq("arst_flags", {59'h0, viol_sticky, first_valid}, 64'h0);
        check_eq("arst_min", peak_min, {4{16'h7FFF}});
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/range_monitor_real.md
# range_monitor_real

Clocked, multi-channel range monitor for signed fixed-point real signals. Each channel is checked against its own inclusive runtime bounds on every valid sample. The block keeps sticky per-channel violation flags, saturating violation counters, observed peak (min/max) values, and a first-violation capture record. It sits beside datapaths as a synthesizable checker that can be read out on hardware, and can optionally halt simulation on the first violation.

## Interface
- N_CH, 4: number of monitored channels, at least 1.
- WIDTH, 16: fixed-point word width per channel, two's complement.
- EXPONENT, -8: binary exponent of all words; used only for simulation messages (real value = word * 2^EXPONENT).
- CNT_WIDTH, 8: width of each per-channel violation counter.
- HALT, 0: 1 = simulation `$display` plus `$finish` on first captured violation; 0 = flag only. Code is excluded under `SYNTHESIS`.
- CH_W (localparam): max(1, $clog2(N_CH)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_data is sampled this cycle.
- in_data  input  N_CH*WIDTH  packed samples; channel c occupies bits [c*WIDTH +: WIDTH].
- lo_bound  input  N_CH*WIDTH  per-channel inclusive lower bound; same packing.
- hi_bound  input  N_CH*WIDTH  per-channel inclusive upper bound; same packing.
- clear  input  1  synchronous clear of all monitor state.
- viol_now  output  N_CH  registered per-channel violation of the last valid sample.
- viol_sticky  output  N_CH  per-channel sticky violation flags.
- viol_any  output  1  OR of viol_sticky.
- viol_count  output  N_CH*CNT_WIDTH  per-channel saturating violation counts.
- first_valid  output  1  first-violation record is held.
- first_ch  output  CH_W  channel of the first violation.
- first_data  output  WIDTH  sample value of the first violation.
- peak_valid  output  1  at least one valid sample has been seen since reset or clear.
- peak_min, peak_max  output  N_CH*WIDTH  per-channel smallest and largest sample seen.

## Operation
- Violation test per channel: `!(lo <= x && x <= hi)`, signed compare at full WIDTH. If lo > hi, every sample violates.
- On a valid sample, with no clear, each channel c:
  - viol_now[c] takes the test result.
  - viol_sticky[c] is OR-set by a violation.
  - viol_count[c] increments on a violation and saturates at 2^CNT_WIDTH-1, never wrapping.
  - peak_min and peak_max update with signed min and max.
  - peak_valid is set.
- First-violation capture: if first_valid=0 and any channel violates, load first_ch with the lowest violating channel index and first_data with that channel's sample, and set first_valid. The record is then frozen until clear or reset.
- When in_valid=0: viol_now is cleared to 0. All other state holds.
- clear=1 returns all state to reset values and dominates a same-cycle in_valid; that sample is discarded entirely.
- HALT=1: in the cycle first_valid rises, print channel, real value, and real bounds, then `$finish`.
- No state machine beyond the capture flag: the first-capture path is IDLE (first_valid=0) -> CAPTURED (first_valid=1) on the first violation; CAPTURED -> IDLE only on clear or reset.

## Timing
- Latency is 1 cycle: a sample presented before edge k is reflected in all outputs after edge k. All outputs are registered except viol_any, which is a combinational OR of registered flags.
- Reset (rst_n=0, asynchronous) and clear values:
  - viol_now, viol_sticky, viol_any, viol_count, first_valid, first_ch, first_data, peak_valid: 0.
  - peak_min: most positive value, 2^(WIDTH-1)-1.
  - peak_max: most negative value, -2^(WIDTH-1).
- Reset deassertion mid-stream: the first edge after release samples normally.
- Bounds are sampled in the same cycle as in_data. Bounds may change every cycle.
- Counter at saturation with a further violation: the counter holds at all-ones and the sticky flag stays set.

## Test plan
- Reset and idle: assert rst_n=0 mid-cycle. All outputs reach reset values immediately. peak_min=0x7FFF and peak_max=0x8000 (WIDTH=16).
- In-range and boundary: lo=-100, hi=100 on all channels; send samples -100, 100, 0, 0. No violations, viol_count=0. peak_min[0]=-100, peak_max[1]=100 after 1 cycle.
- Simultaneous violation: ch1=101 and ch3=-101 in one valid cycle. viol_now=4'b1010, viol_sticky=4'b1010, first_ch=1, first_data=101. A later ch0=500 leaves first_ch=1.
- Saturation: CNT_WIDTH=8; drive 300 consecutive violating samples on ch2. viol_count[2]=255 and holds there. Other counters stay 0.
- Clear priority: clear=1 together with a violating sample. Next cycle all state is at reset values and viol_count=0. The following violation recaptures first_*.
- Inverted bounds and gaps: lo=10, hi=-10 -> every valid sample sets viol_now. in_valid=0 cycles -> viol_now=0, counters unchanged.
